// File: rtl/dma_desc_pkg.sv
// Shared types and chunk math for the DMA descriptor splitter and its wrappers.
package dma_desc_pkg;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_LEN_W  = 32;
  localparam int MAX_SRC_W  = 4;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_LEN_W-1:0]  len;
  } dsc_cmd_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_LEN_W-1:0]  len;
    logic [MAX_SRC_W-1:0]  src;
    logic                  last;
  } dsc_byp_t;

  // Bytes left before the next max_bytes-aligned boundary, capped by rem_len.
  function automatic logic [MAX_LEN_W-1:0] desc_chunk(
    input logic [MAX_ADDR_W-1:0] addr,
    input logic [MAX_LEN_W-1:0]  rem_len,
    input logic [MAX_LEN_W-1:0]  max_bytes
  );
    logic [MAX_LEN_W-1:0] room;
    room = max_bytes - (addr[MAX_LEN_W-1:0] & (max_bytes - MAX_LEN_W'(1)));
    return (rem_len < room) ? rem_len : room;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_vld
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // Walk from farthest to nearest so the nearest hit is written last and wins.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_SRC]) begin
        gnt                                 = '0;
        gnt[(int'(rr_ptr) + k) % NUM_SRC]   = 1'b1;
        gnt_idx                             = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
        gnt_vld                             = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_desc_splitter.sv
// Multi-source command front end: round-robin accept, split at MAX_DESC_BYTES boundaries, drive dsc_byp.
module dma_desc_splitter
  import dma_desc_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int ADDR_W         = 64,
  parameter int LEN_W          = 32,
  parameter int MAX_DESC_BYTES = 4096,
  parameter int SRC_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      pcie_clk,
  input  logic                      pcie_areset,
  input  logic [NUM_SRC-1:0]        s_cmd_valid,
  output logic [NUM_SRC-1:0]        s_cmd_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] s_cmd_addr,
  input  logic [NUM_SRC*LEN_W-1:0]  s_cmd_len,
  input  logic                      dsc_byp_ready,
  output logic                      dsc_byp_load,
  output logic [ADDR_W-1:0]         dsc_byp_addr,
  output logic [LEN_W-1:0]          dsc_byp_len,
  output logic [SRC_W-1:0]          dsc_byp_src,
  output logic                      dsc_byp_last,
  output logic                      cmd_done_valid,
  output logic [SRC_W-1:0]          cmd_done_src,
  output logic [31:0]               desc_count
);
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state, state_nxt;
  dsc_cmd_t             cur_q, cur_nxt;
  logic [SRC_W-1:0]     src_q, src_nxt, rr_ptr, rr_nxt, done_src_nxt;
  logic                 done_nxt, xfer, issuing, last;
  logic [NUM_SRC-1:0]   gnt;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic [ADDR_W-1:0]    req_addr;
  logic [LEN_W-1:0]     req_len;
  logic [MAX_LEN_W-1:0] chunk;

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return SRC_W'((int'(s) + 1) % NUM_SRC);
  endfunction

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
    .req     (s_cmd_valid),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_addr = s_cmd_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign req_len  = s_cmd_len[int'(gnt_idx)*LEN_W +: LEN_W];
  assign chunk    = desc_chunk(cur_q.addr, cur_q.len, MAX_LEN_W'(MAX_DESC_BYTES));
  assign issuing  = (state == ISSUE);
  assign last     = (cur_q.len == chunk);

  // Fields are forced to zero outside ISSUE so reset clears them asynchronously.
  assign dsc_byp_load = issuing;
  assign dsc_byp_addr = issuing ? cur_q.addr[ADDR_W-1:0] : '0;
  assign dsc_byp_len  = issuing ? chunk[LEN_W-1:0] : '0;
  assign dsc_byp_src  = issuing ? src_q : '0;
  assign dsc_byp_last = issuing & last;

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur_q;
    src_nxt      = src_q;
    rr_nxt       = rr_ptr;
    s_cmd_ready  = '0;
    done_nxt     = 1'b0;
    done_src_nxt = src_q;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_vld && !pcie_areset) begin
          s_cmd_ready  = gnt;
          cur_nxt.addr = MAX_ADDR_W'(req_addr);
          cur_nxt.len  = MAX_LEN_W'(req_len);
          src_nxt      = gnt_idx;
          if (req_len == '0) begin
            done_nxt     = 1'b1;
            done_src_nxt = gnt_idx;
            rr_nxt       = next_src(gnt_idx);
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (dsc_byp_ready) begin
          xfer         = 1'b1;
          cur_nxt.addr = cur_q.addr + MAX_ADDR_W'(chunk);
          cur_nxt.len  = cur_q.len - chunk;
          if (last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            rr_nxt    = next_src(src_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or posedge pcie_areset) begin
    if (pcie_areset) begin
      state          <= IDLE;
      cur_q          <= '0;
      src_q          <= '0;
      rr_ptr         <= '0;
      cmd_done_valid <= 1'b0;
      cmd_done_src   <= '0;
      desc_count     <= '0;
    end else begin
      state          <= state_nxt;
      cur_q          <= cur_nxt;
      src_q          <= src_nxt;
      rr_ptr         <= rr_nxt;
      cmd_done_valid <= done_nxt;
      if (done_nxt) cmd_done_src <= done_src_nxt;
      if (xfer) desc_count <= desc_count + 32'd1;
    end
  end
endmodule
